imem_loader: RTL and testbench

Upstream program-load stage for the single-cycle core. It takes a byte stream from slow, asynchronous pins and assembles it into 32-bit little-endian words. Each word is presented on the core's instruction-memory write port (imem_wr_data / imem_wr_en) as a one-cycle write pulse. While loading, it holds the core's PC/regfile in reset, then releases it to run.

---
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: synchronises an async byte stream, packs little-endian 32-bit words
// into imem write pulses, and holds the core in reset until the load finishes.
module imem_loader #(
  parameter int NUM_WORDS   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic [7:0]  byte_in,
  input  logic        byte_strobe,
  output logic [31:0] imem_wr_data,
  output logic        imem_wr_en,
  output logic        cpu_rst_n,
  output logic        loading,
  output logic [7:0]  word_count,
  output logic        load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [7:0] NUM_W8 = 8'(NUM_WORDS);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_sync_q, stb_sync_q;
  logic                   req_prev_q, stb_prev_q;
  logic [1:0]             idx_q, idx_d;
  logic [23:0]            asm_q, asm_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic [7:0]             cnt_q, cnt_d;

  logic load_req_s, strobe_s, byte_evt, load_req_rise;

  assign load_req_s    = req_sync_q[SYNC_STAGES-1];
  assign strobe_s      = stb_sync_q[SYNC_STAGES-1];
  assign byte_evt      = strobe_s & ~stb_prev_q;
  assign load_req_rise = load_req_s & ~req_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      stb_sync_q <= '0;
      req_prev_q <= 1'b0;
      stb_prev_q <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      asm_q      <= 24'd0;
      wr_data_q  <= 32'd0;
      wr_en_q    <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], load_req};
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], byte_strobe};
      req_prev_q <= load_req_s;
      stb_prev_q <= strobe_s;
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      cnt_q      <= cnt_d;
    end
  end

  // The write pulse and count are registered together, so a pulse launched on the
  // last accepted byte always completes even if the state leaves LOAD next edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_req_s) begin
          state_d = LOAD;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
        end
      end
      LOAD: begin
        if (!load_req_s || cnt_q == NUM_W8) begin
          state_d = RUN;
        end else if (byte_evt) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: asm_d[7:0]   = byte_in;
            2'd1: asm_d[15:8]  = byte_in;
            2'd2: asm_d[23:16] = byte_in;
            default: begin
              wr_data_d = {byte_in, asm_q};
              wr_en_d   = 1'b1;
              cnt_d     = cnt_q + 8'd1;
            end
          endcase
        end
      end
      RUN: begin
        if (load_req_rise) begin
          state_d = LOAD;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_wr_data = wr_data_q;
  assign imem_wr_en   = wr_en_q;
  assign cpu_rst_n    = (state_q == RUN);
  assign loading      = (state_q == LOAD);
  assign load_done    = (state_q == RUN);
  assign word_count   = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by an independent monitor on every write pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic [7:0]  byte_in;
  logic        byte_strobe;
  logic [31:0] imem_wr_data;
  logic        imem_wr_en;
  logic        cpu_rst_n;
  logic        loading;
  logic [7:0]  word_count;
  logic        load_done;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic        prev_en = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.NUM_WORDS(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .byte_in      (byte_in),
    .byte_strobe  (byte_strobe),
    .imem_wr_data (imem_wr_data),
    .imem_wr_en   (imem_wr_en),
    .cpu_rst_n    (cpu_rst_n),
    .loading      (loading),
    .word_count   (word_count),
    .load_done    (load_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the next queued word and count.
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst_n && imem_wr_en) begin
      total++;
      if (prev_en) begin
        bad++;
        $display("FAIL back_to_back_write: got two pulses expected one");
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got data 0x%08h expected no write", imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", imem_wr_data, e[31:0]);
        check("wr_count", {24'd0, word_count}, {24'd0, e[39:32]});
      end
    end
    prev_en = rst_n && imem_wr_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in     = b;
    byte_strobe = 1'b1;
    tick(5);
    byte_strobe = 1'b0;
    tick(5);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [7:0] cnt);
    exp_q.push_back({cnt, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_status(input string tag, input logic cpu, input logic ld,
                              input logic done, input logic [7:0] cnt);
    @(negedge clk);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, cpu});
    check({tag, "_loading"}, {31'd0, loading}, {31'd0, ld});
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_word_count"}, {24'd0, word_count}, {24'd0, cnt});
  endtask

  initial begin
    rst_n       = 1'b0;
    load_req    = 1'b0;
    byte_in     = 8'h00;
    byte_strobe = 1'b0;
    #3;
    check("rst_wr_data", imem_wr_data, 32'd0);
    check("rst_wr_en", {31'd0, imem_wr_en}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("rst_loading", {31'd0, loading}, 32'd0);
    check("rst_word_count", {24'd0, word_count}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Two-word load, core held in reset throughout.
    load_req = 1'b1;
    tick(4);
    check_status("load_entry", 1'b0, 1'b1, 1'b0, 8'd0);
    send_word(32'h0010_0013, 8'd1);
    send_word(32'h0020_0093, 8'd2);
    check_status("two_words", 1'b0, 1'b1, 1'b0, 8'd2);

    // Complete the 4-word load; extra strobes in RUN must not write.
    send_word(32'hCAFE_F00D, 8'd3);
    send_word(32'h1234_5678, 8'd4);
    check_status("complete", 1'b1, 1'b0, 1'b1, 8'd4);
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    check_status("run_ignores_bytes", 1'b1, 1'b0, 1'b1, 8'd4);
    check("run_wr_data_held", imem_wr_data, 32'h1234_5678);

    // Reload from RUN on a fresh load_req rising edge.
    load_req = 1'b0;
    tick(4);
    load_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reload_cpu_still_run", {31'd0, cpu_rst_n}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("reload_cpu_rst_low", {31'd0, cpu_rst_n}, 32'd0);
    check("reload_count_clear", {24'd0, word_count}, 32'd0);
    tick(1);
    send_word(32'hDEAD_BEEF, 8'd1);

    // Two more bytes then early termination: partial word dropped.
    send_byte(8'h77);
    send_byte(8'h66);
    load_req = 1'b0;
    tick(5);
    check_status("early_term", 1'b1, 1'b0, 1'b1, 8'd1);
    check("early_term_data", imem_wr_data, 32'hDEAD_BEEF);

    // Asynchronous reset after three bytes discards progress.
    load_req = 1'b1;
    tick(5);
    send_byte(8'h99);
    send_byte(8'h88);
    send_byte(8'h77);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_wr_data", imem_wr_data, 32'd0);
    check("async_rst_loading", {31'd0, loading}, 32'd0);
    check("async_rst_count", {24'd0, word_count}, 32'd0);
    check("async_rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    send_word(32'h4433_2211, 8'd1);

    // Byte event coincides with load_req_s falling: byte dropped, RUN entered.
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    byte_in     = 8'h04;
    byte_strobe = 1'b1;
    load_req    = 1'b0;
    tick(5);
    byte_strobe = 1'b0;
    tick(5);
    check_status("collide", 1'b1, 1'b0, 1'b1, 8'd1);
    check("collide_data", imem_wr_data, 32'h4433_2211);

    tick(3);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
